alu: RTL and testbench



---
 rtl/alu.sv | 79 +++++++
 tb/tb_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 8-bit ALU: 16 opcodes, 9-bit result with carry/borrow/shift-out in bit 8.
// One-cycle latency, one operation per clock, synchronous active-low reset.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [3:0] control,
  output logic [8:0] z
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;
  localparam logic [3:0] OP_MAX = 4'd15;

  logic [8:0] z_q;
  logic [8:0] z_d;
  logic [8:0] x_ext;
  logic [8:0] y_ext;
  logic [7:0] mul_lo;
  logic       eq_u;
  logic       lt_u;
  logic       lt_s;

  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign mul_lo = {4'b0000, x[3:0]} * {4'b0000, y[3:0]};
  assign eq_u   = (x == y);
  assign lt_u   = (x < y);
  assign lt_s   = ($signed(x) < $signed(y));

  // 9-bit wraparound on SUB/DEC puts the borrow directly into bit 8.
  always_comb begin
    z_d = 9'h000;
    case (control)
      OP_ADD: z_d = x_ext + y_ext;
      OP_SUB: z_d = x_ext - y_ext;
      OP_INC: z_d = x_ext + 9'd1;
      OP_DEC: z_d = x_ext - 9'd1;
      OP_AND: z_d = {1'b0, x & y};
      OP_OR:  z_d = {1'b0, x | y};
      OP_XOR: z_d = {1'b0, x ^ y};
      OP_NOT: z_d = {1'b0, ~x};
      OP_SHL: z_d = {x[7], x[6:0], 1'b0};
      OP_SHR: z_d = {x[0], 1'b0, x[7:1]};
      OP_ASR: z_d = {x[0], x[7], x[7:1]};
      OP_ROL: z_d = {x[7], x[6:0], x[7]};
      OP_ROR: z_d = {x[0], x[0], x[7:1]};
      OP_MUL: z_d = {1'b0, mul_lo};
      OP_CMP: z_d = {5'b00000, lt_s, ~eq_u & ~lt_u, lt_u, eq_u};
      OP_MAX: z_d = lt_u ? y_ext : x_ext;
      default: z_d = 9'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= 9'h000;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed and back-to-back sweep bench for alu; expected values come from
// hand-computed vectors and an integer-arithmetic reference function.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] y;
  logic [3:0] control;
  logic [8:0] z;

  int n_checks;
  int n_errors;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (x),
    .y       (y),
    .control (control),
    .z       (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%03h exp=0x%03h", tag, got, exp);
    end else begin
      $display("ok   %s z=0x%03h", tag, got);
    end
  endtask

  // Reference built from plain integer arithmetic rather than bit slicing.
  function automatic logic [8:0] model(input logic [7:0] a8, input logic [7:0] b8,
                                       input logic [3:0] op);
    int a, b, r, sa, sb;
    a  = int'(a8);
    b  = int'(b8);
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = (a - b + 512) % 512;
      4'd2:  r = a + 1;
      4'd3:  r = (a + 511) % 512;
      4'd4:  r = int'(a8 & b8);
      4'd5:  r = int'(a8 | b8);
      4'd6:  r = int'(a8 ^ b8);
      4'd7:  r = 255 - a;
      4'd8:  r = a * 2;
      4'd9:  r = a / 2 + (a % 2) * 256;
      4'd10: r = a / 2 + ((a >= 128) ? 128 : 0) + (a % 2) * 256;
      4'd11: r = (a * 2) % 256 + (a / 128) + (a / 128) * 256;
      4'd12: r = a / 2 + (a % 2) * 128 + (a % 2) * 256;
      4'd13: r = (a % 16) * (b % 16);
      4'd14: r = ((a == b) ? 1 : 0) + ((a < b) ? 2 : 0) + ((a > b) ? 4 : 0) + ((sa < sb) ? 8 : 0);
      default: r = (a > b) ? a : b;
    endcase
    return r[8:0];
  endfunction

  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    control = op;
    x       = a;
    y       = b;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      tag;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] exp_prev;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    x = 8'hFF; y = 8'hFF; control = 4'd0;

    @(posedge clk); #1;
    check("rst_edge1", z, 9'h000);
    @(posedge clk); #1;
    check("rst_edge2", z, 9'h000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_add", z, 9'h1FE);

    vecs.push_back('{"add_carry", 4'd0,  8'hFF, 8'h01, 9'h100});
    vecs.push_back('{"sub_borrow",4'd1,  8'h10, 8'h20, 9'h1F0});
    vecs.push_back('{"dec_zero",  4'd3,  8'h00, 8'h55, 9'h1FF});
    vecs.push_back('{"inc_7f",    4'd2,  8'h7F, 8'h00, 9'h080});
    vecs.push_back('{"inc_ff",    4'd2,  8'hFF, 8'h00, 9'h100});
    vecs.push_back('{"and",       4'd4,  8'hA5, 8'h3C, 9'h024});
    vecs.push_back('{"or",        4'd5,  8'hA5, 8'h3C, 9'h0BD});
    vecs.push_back('{"xor",       4'd6,  8'hA5, 8'h3C, 9'h099});
    vecs.push_back('{"not",       4'd7,  8'hA5, 8'h3C, 9'h05A});
    vecs.push_back('{"shl",       4'd8,  8'h81, 8'h00, 9'h102});
    vecs.push_back('{"shr",       4'd9,  8'h81, 8'h00, 9'h140});
    vecs.push_back('{"asr",       4'd10, 8'h81, 8'h00, 9'h1C0});
    vecs.push_back('{"rol",       4'd11, 8'h81, 8'h00, 9'h103});
    vecs.push_back('{"ror",       4'd12, 8'h81, 8'h00, 9'h1C0});
    vecs.push_back('{"mul4",      4'd13, 8'hFF, 8'h0F, 9'h0E1});
    vecs.push_back('{"cmp_sgn",   4'd14, 8'h80, 8'h01, 9'h00C});
    vecs.push_back('{"cmp_eq",    4'd14, 8'h42, 8'h42, 9'h001});
    vecs.push_back('{"cmp_lt",    4'd14, 8'h01, 8'h80, 9'h002});
    vecs.push_back('{"max",       4'd15, 8'h80, 8'h7F, 9'h080});
    vecs.push_back('{"max_swap",  4'd15, 8'h10, 8'hF0, 9'h0F0});

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].tag, z, vecs[i].exp);
    end

    // Mid-stream reset: the in-flight result is discarded.
    apply(4'd0, 8'h12, 8'h34);
    rst_n = 1'b0;
    apply(4'd0, 8'h01, 8'h01);
    check("rst_midstream", z, 9'h000);
    rst_n = 1'b1;
    apply(4'd1, 8'h05, 8'h03);
    check("after_rst_sub", z, 9'h002);

    // Back-to-back sweep: inputs change every cycle.
    exp_prev = 9'h000;
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 3; k++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        apply(4'(op), ra, rb);
        exp_prev = model(ra, rb, 4'(op));
        check($sformatf("sweep_op%0d_%02h_%02h", op, ra, rb), z, exp_prev);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
